// File: rtl/elevator_scan_scheduler.sv
// Multi-car SCAN elevator scheduler: latches floor calls on rising edges and
// runs one independent sweep state machine (idle / moving / door) per car.
module elevator_scan_scheduler #(
  parameter int NUM_CARS      = 2,
  parameter int NUM_FLOORS    = 6,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 60,
  parameter int DWELL_CYCLES  = 30,
  parameter int TIMER_W       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             halt,
  input  logic [NUM_CARS*NUM_FLOORS-1:0]   floor_destinations,
  input  logic [NUM_CARS*NUM_FLOORS-1:0]   floors_requested,
  output logic [NUM_CARS*FLOOR_W-1:0]      car_floor,
  output logic [NUM_CARS-1:0]              car_dir,
  output logic [NUM_CARS-1:0]              car_moving,
  output logic [NUM_CARS-1:0]              door_open,
  output logic [NUM_CARS*NUM_FLOORS-1:0]   served,
  output logic [NUM_CARS*NUM_FLOORS-1:0]   pending
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DOOR   = 2'd2
  } state_e;

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DWELL_LOAD  = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  // Returns {here, above, below} for the pending calls relative to floor f.
  function automatic logic [2:0] decode_calls(input logic [NUM_FLOORS-1:0] pend,
                                              input logic [FLOOR_W-1:0]    f);
    logic h, a, b;
    h = 1'b0;
    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i]) begin
        if (i == int'(f))      h = 1'b1;
        else if (i > int'(f))  a = 1'b1;
        else                   b = 1'b1;
      end
    end
    return {h, a, b};
  endfunction

  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (i == int'(f));
    end
    return m;
  endfunction

  for (genvar c = 0; c < NUM_CARS; c++) begin : g_car
    logic [NUM_FLOORS-1:0] call_s, rise_s, hist_q, pend_q, served_q;
    logic [FLOOR_W-1:0]    floor_q, next_floor_s;
    logic [TIMER_W-1:0]    timer_q;
    logic                  dir_q, moving_q, door_q;
    logic [2:0]            cur_s, nxt_s;
    logic                  ahead_cur_s, behind_cur_s, ahead_nxt_s, behind_nxt_s;
    state_e                state_q;

    assign call_s = floor_destinations[c*NUM_FLOORS +: NUM_FLOORS]
                  | floors_requested[c*NUM_FLOORS +: NUM_FLOORS];
    assign rise_s = call_s & ~hist_q;

    // Floor reached when the current travel leg completes, clamped at the shaft ends.
    always_comb begin
      next_floor_s = floor_q;
      if (dir_q && (floor_q != TOP_FLOOR)) begin
        next_floor_s = floor_q + FLOOR_W'(1);
      end else if (!dir_q && (floor_q != {FLOOR_W{1'b0}})) begin
        next_floor_s = floor_q - FLOOR_W'(1);
      end else begin
        next_floor_s = floor_q;
      end
    end

    assign cur_s        = decode_calls(pend_q, floor_q);
    assign nxt_s        = decode_calls(pend_q, next_floor_s);
    assign ahead_cur_s  = dir_q ? cur_s[1] : cur_s[0];
    assign behind_cur_s = dir_q ? cur_s[0] : cur_s[1];
    assign ahead_nxt_s  = dir_q ? nxt_s[1] : nxt_s[0];
    assign behind_nxt_s = dir_q ? nxt_s[0] : nxt_s[1];

    // Call latch plus per-car SCAN state machine; a service clear overrides a same-cycle set.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q  <= ST_IDLE;
        floor_q  <= {FLOOR_W{1'b0}};
        dir_q    <= 1'b1;
        timer_q  <= {TIMER_W{1'b0}};
        pend_q   <= {NUM_FLOORS{1'b0}};
        served_q <= {NUM_FLOORS{1'b0}};
        moving_q <= 1'b0;
        door_q   <= 1'b0;
        // History tracks the live level so a call held through reset needs a fresh edge.
        hist_q   <= call_s;
      end else begin
        hist_q   <= call_s;
        served_q <= {NUM_FLOORS{1'b0}};
        pend_q   <= pend_q | rise_s;
        if (!halt) begin
          case (state_q)
            ST_IDLE: begin
              if (cur_s[2]) begin
                state_q  <= ST_DOOR;
                timer_q  <= DWELL_LOAD;
                pend_q   <= (pend_q | rise_s) & ~floor_mask(floor_q);
                served_q <= floor_mask(floor_q);
                door_q   <= 1'b1;
              end else if (cur_s[1] || cur_s[0]) begin
                if (!(cur_s[1] && cur_s[0])) dir_q <= cur_s[1];
                else                         dir_q <= dir_q;
                state_q  <= ST_MOVING;
                timer_q  <= TRAVEL_LOAD;
                moving_q <= 1'b1;
              end else begin
                state_q  <= ST_IDLE;
              end
            end
            ST_MOVING: begin
              if (timer_q != {TIMER_W{1'b0}}) begin
                timer_q <= timer_q - TIMER_W'(1);
              end else begin
                floor_q <= next_floor_s;
                if (nxt_s[2]) begin
                  state_q  <= ST_DOOR;
                  timer_q  <= DWELL_LOAD;
                  pend_q   <= (pend_q | rise_s) & ~floor_mask(next_floor_s);
                  served_q <= floor_mask(next_floor_s);
                  moving_q <= 1'b0;
                  door_q   <= 1'b1;
                end else if (ahead_nxt_s) begin
                  timer_q  <= TRAVEL_LOAD;
                end else if (behind_nxt_s) begin
                  dir_q    <= ~dir_q;
                  timer_q  <= TRAVEL_LOAD;
                end else begin
                  state_q  <= ST_IDLE;
                  moving_q <= 1'b0;
                end
              end
            end
            ST_DOOR: begin
              if (cur_s[2]) begin
                timer_q  <= DWELL_LOAD;
                pend_q   <= (pend_q | rise_s) & ~floor_mask(floor_q);
                served_q <= floor_mask(floor_q);
              end else if (timer_q != {TIMER_W{1'b0}}) begin
                timer_q  <= timer_q - TIMER_W'(1);
              end else if (ahead_cur_s || behind_cur_s) begin
                if (!ahead_cur_s) dir_q <= ~dir_q;
                else              dir_q <= dir_q;
                state_q  <= ST_MOVING;
                timer_q  <= TRAVEL_LOAD;
                moving_q <= 1'b1;
                door_q   <= 1'b0;
              end else begin
                state_q  <= ST_IDLE;
                door_q   <= 1'b0;
              end
            end
            default: begin
              state_q  <= ST_IDLE;
              moving_q <= 1'b0;
              door_q   <= 1'b0;
            end
          endcase
        end
      end
    end

    assign car_floor[c*FLOOR_W +: FLOOR_W]    = floor_q;
    assign car_dir[c]                         = dir_q;
    assign car_moving[c]                      = moving_q;
    assign door_open[c]                       = door_q;
    assign served[c*NUM_FLOORS +: NUM_FLOORS]  = served_q;
    assign pending[c*NUM_FLOORS +: NUM_FLOORS] = pend_q;
  end

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Directed bench for elevator_scan_scheduler with TRAVEL_CYCLES=4, DWELL_CYCLES=3.
module tb_elevator_scan_scheduler;

  logic        clk;
  logic        rst;
  logic        halt;
  logic [11:0] fd;
  logic [11:0] fr;
  logic [5:0]  car_floor;
  logic [1:0]  car_dir;
  logic [1:0]  car_moving;
  logic [1:0]  door_open;
  logic [11:0] served;
  logic [11:0] pending;

  int vectors;
  int miscompares;
  int cyc;

  elevator_scan_scheduler #(
    .NUM_CARS(2), .NUM_FLOORS(6), .FLOOR_W(3),
    .TRAVEL_CYCLES(4), .DWELL_CYCLES(3), .TIMER_W(8)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .floor_destinations(fd), .floors_requested(fr),
    .car_floor(car_floor), .car_dir(car_dir), .car_moving(car_moving),
    .door_open(door_open), .served(served), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    rst = 1'b0; halt = 1'b0; fd = 12'h000; fr = 12'h000;
    tick(); tick();
    rst = 1'b1;
    check("rst_floor",   32'(car_floor),  32'h0);
    check("rst_dir",     32'(car_dir),    32'h3);
    check("rst_door",    32'(door_open),  32'h0);
    check("rst_moving",  32'(car_moving), 32'h0);
    check("rst_pending", 32'(pending),    32'h0);
    check("rst_served",  32'(served),     32'h0);

    // Single up-trip, car 0 to floor 3
    cyc = 0;
    fd[3] = 1'b1; tick(); fd[3] = 1'b0;
    check("up_pend1",    32'(pending),        32'h008);
    check("up_idle1",    32'(car_moving),     32'h0);
    go_to(2);  check("up_mov2",   32'(car_moving),     32'h1);
    go_to(5);  check("up_fl5",    32'(car_floor[2:0]), 32'd0);
    go_to(6);  check("up_fl6",    32'(car_floor[2:0]), 32'd1);
    go_to(10); check("up_fl10",   32'(car_floor[2:0]), 32'd2);
    go_to(14); check("up_fl14",   32'(car_floor[2:0]), 32'd3);
    check("up_srv14",  32'(served),     32'h008);
    check("up_door14", 32'(door_open),  32'h1);
    check("up_mov14",  32'(car_moving), 32'h0);
    check("up_pend14", 32'(pending),    32'h000);
    go_to(15); check("up_srv15",  32'(served),    32'h000);
    go_to(16); check("up_door16", 32'(door_open), 32'h1);
    go_to(17); check("up_door17", 32'(door_open), 32'h0);
    check("up_mov17",  32'(car_moving), 32'h0);

    // SCAN ordering, car 1: 4 then 5, reverse, then 1, never stopping at 3
    cyc = 0;
    fd[10] = 1'b1; tick(); fd[10] = 1'b0;
    go_to(6);  check("scan_fl6", 32'(car_floor[5:3]), 32'd1);
    go_to(7);  fd[7] = 1'b1; tick(); fd[7] = 1'b0;
    check("scan_pend8", 32'(pending[11:6]), 32'b010010);
    go_to(10); check("scan_fl10",  32'(car_floor[5:3]), 32'd2);
    check("scan_mov10", 32'(car_moving[1]), 32'h1);
    go_to(11); fr[11] = 1'b1; tick(); fr[11] = 1'b0;
    check("scan_pend12", 32'(pending[11:6]), 32'b110010);
    go_to(14); check("scan_fl14", 32'(car_floor[5:3]), 32'd3);
    check("scan_nodoor3", 32'(door_open[1]),  32'h0);
    check("scan_mov14",   32'(car_moving[1]), 32'h1);
    go_to(18); check("scan_fl18", 32'(car_floor[5:3]), 32'd4);
    check("scan_srv4",  32'(served[11:6]), 32'b010000);
    check("scan_door4", 32'(door_open[1]), 32'h1);
    go_to(21); check("scan_mov21", 32'(car_moving[1]), 32'h1);
    go_to(25); check("scan_fl25", 32'(car_floor[5:3]), 32'd5);
    check("scan_srv5",  32'(served[11:6]), 32'b100000);
    go_to(27); check("scan_dir27", 32'(car_dir[1]), 32'h1);
    check("scan_door27", 32'(door_open[1]), 32'h1);
    go_to(28); check("scan_dir28", 32'(car_dir[1]), 32'h0);
    check("scan_mov28", 32'(car_moving[1]), 32'h1);
    go_to(32); check("scan_fl32", 32'(car_floor[5:3]), 32'd4);
    check("scan_nodoor4", 32'(door_open[1]), 32'h0);
    go_to(44); check("scan_fl44", 32'(car_floor[5:3]), 32'd1);
    check("scan_srv1",   32'(served[11:6]),  32'b000010);
    check("scan_pend44", 32'(pending[11:6]), 32'h0);
    go_to(47); check("scan_door47", 32'(door_open[1]), 32'h0);
    check("scan_mov47", 32'(car_moving[1]), 32'h0);
    check("scan_dir47", 32'(car_dir[1]),    32'h0);

    // Door re-open, car 0 from floor 3 down to floor 2
    cyc = 0;
    fd[2] = 1'b1; tick(); fd[2] = 1'b0;
    go_to(2); check("ro_mov2", 32'(car_moving[0]), 32'h1);
    check("ro_dir2", 32'(car_dir[0]), 32'h0);
    go_to(6); check("ro_fl6", 32'(car_floor[2:0]), 32'd2);
    check("ro_srv6",  32'(served[5:0]), 32'b000100);
    check("ro_door6", 32'(door_open[0]), 32'h1);
    go_to(7); fd[2] = 1'b1; tick(); fd[2] = 1'b0;
    check("ro_pend8", 32'(pending[5:0]), 32'b000100);
    check("ro_door8", 32'(door_open[0]), 32'h1);
    go_to(9);  check("ro_srv9",   32'(served[5:0]),  32'b000100);
    check("ro_pend9", 32'(pending[5:0]), 32'h0);
    go_to(11); check("ro_door11", 32'(door_open[0]), 32'h1);
    go_to(12); check("ro_door12", 32'(door_open[0]), 32'h0);

    // Halt mid-travel, car 0 from floor 2 up toward floor 5
    cyc = 0;
    fd[5] = 1'b1; tick(); fd[5] = 1'b0;
    go_to(2); check("h_dir2", 32'(car_dir[0]), 32'h1);
    go_to(3); halt = 1'b1;
    go_to(5); fd[0] = 1'b1; tick(); fd[0] = 1'b0;
    check("h_pend6", 32'(pending[5:0]), 32'b100001);
    go_to(12); check("h_fl12", 32'(car_floor[2:0]), 32'd2);
    check("h_mov12", 32'(car_moving[0]), 32'h1);
    go_to(13); halt = 1'b0;
    go_to(15); check("h_fl15", 32'(car_floor[2:0]), 32'd2);
    go_to(16); check("h_fl16", 32'(car_floor[2:0]), 32'd3);
    go_to(20); check("h_fl20", 32'(car_floor[2:0]), 32'd4);
    check("h_pend20", 32'(pending[5:0]), 32'b100001);

    // Reset mid-travel with a hall call held high through reset
    rst = 1'b0; fr[3] = 1'b1; tick(); rst = 1'b1;
    check("mr_floor",   32'(car_floor),  32'h0);
    check("mr_moving",  32'(car_moving), 32'h0);
    check("mr_door",    32'(door_open),  32'h0);
    check("mr_dir",     32'(car_dir),    32'h3);
    check("mr_pending", 32'(pending),    32'h0);
    tick();    check("mr_pend22", 32'(pending), 32'h0);
    go_to(24); check("mr_pend24", 32'(pending), 32'h0);
    check("mr_idle24", 32'(car_moving), 32'h0);
    fr[3] = 1'b0; tick(); fr[3] = 1'b1; tick();
    check("mr_relatch", 32'(pending[5:0]), 32'b001000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
